// File: rtl/stim_sequencer.sv
// Stimulation burst sequencer: ramp-up, full-amplitude, optional ramp-down and silent phases,
// one pulse request per period tick. Define STIM_RAMP_DOWN_EN to enable the ramp-down phase.
`timescale 1ns/1ps
module stim_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [11:0] freq,
  input  logic [5:0]  amplitude,
  input  logic [5:0]  ramp,
  input  logic [9:0]  ramp_factor,
  input  logic [7:0]  on_time,
  input  logic [9:0]  off_time,
  input  logic        pulse_ack,
  output logic        pulse_req,
  output logic [5:0]  dac_amp,
  output logic        stim_active,
  output logic [2:0]  state,
  output logic        overrun
);

  localparam int unsigned CNT_W  = 12;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned PCNT_W = 10;
  localparam int unsigned AMP_W  = 6;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RAMP = 3'd1;
  localparam logic [2:0] S_ON   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_OFF  = 3'd4;

  logic [2:0]        state_nxt, start_state, after_ramp, after_on;
  logic [CNT_W-1:0]  cnt, cnt_nxt, period_m1;
  logic [PCNT_W-1:0] pcnt, pcnt_nxt, pcnt_inc;
  logic [ACC_W-1:0]  acc, acc_nxt, acc_cap, acc_up;
  logic [ACC_W:0]    acc_sum;
  logic [AMP_W-1:0]  dac_nxt, issue_amp;
  logic              req_nxt, ovr_nxt, active_nxt;
  logic              tick, pending, issue, latch_cfg;

  // Burst configuration, frozen for the duration of a burst
  logic [11:0] freq_q;
  logic [5:0]  amp_q;
  logic [5:0]  ramp_q;
  logic [9:0]  rf_q;
  logic [7:0]  on_q;
  logic [9:0]  off_q;

`ifdef STIM_RAMP_DOWN_EN
  logic [ACC_W-1:0] acc_dn;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    pcnt_nxt    = pcnt;
    acc_nxt     = acc;
    dac_nxt     = dac_amp;
    ovr_nxt     = overrun;
    latch_cfg   = 1'b0;
    issue       = 1'b0;
    issue_amp   = dac_amp;
    pending     = pulse_req & ~pulse_ack;
    req_nxt     = pending;
    tick        = (state != S_IDLE) && (cnt == '0);
    period_m1   = (freq_q < 12'd2) ? 12'd1 : freq_q - 12'd1;
    pcnt_inc    = pcnt + PCNT_W'(1);
    acc_sum     = (ACC_W+1)'(acc) + (ACC_W+1)'(rf_q);
    acc_cap     = {amp_q, 4'b0000};
    acc_up      = (acc_sum > (ACC_W+1)'(acc_cap)) ? acc_cap : acc_sum[ACC_W-1:0];
`ifdef STIM_RAMP_DOWN_EN
    acc_dn      = (acc > rf_q) ? acc - rf_q : '0;
`endif

    // Zero-length phases are skipped when a burst starts (uses live config being latched)
    if (ramp != '0)         start_state = S_RAMP;
    else if (on_time != '0) start_state = S_ON;
    else                    start_state = S_OFF;

`ifdef STIM_RAMP_DOWN_EN
    after_ramp = (on_q != '0) ? S_ON : S_RD;
    after_on   = (ramp_q != '0) ? S_RD : S_OFF;
`else
    after_ramp = (on_q != '0) ? S_ON : S_OFF;
    after_on   = S_OFF;
`endif

    if (state != S_IDLE)
      cnt_nxt = (cnt >= period_m1) ? '0 : cnt + CNT_W'(1);

    if (state == S_IDLE) begin
      cnt_nxt  = '0;
      pcnt_nxt = '0;
      acc_nxt  = '0;
      if (enable) begin
        latch_cfg = 1'b1;
        state_nxt = start_state;
      end
    end else if (!enable) begin
      // Let an outstanding request finish before parking in IDLE
      if (!pending) begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
        pcnt_nxt  = '0;
        acc_nxt   = '0;
      end
    end else if (tick) begin
      case (state)
        S_RAMP: begin
          issue     = 1'b1;
          issue_amp = acc_up[ACC_W-1:4];
          acc_nxt   = acc_up;
          if (pcnt_inc == PCNT_W'(ramp_q)) begin
            pcnt_nxt  = '0;
            state_nxt = after_ramp;
          end else begin
            pcnt_nxt  = pcnt_inc;
          end
        end
        S_ON: begin
          issue     = 1'b1;
          issue_amp = amp_q;
          if (pcnt_inc == PCNT_W'(on_q)) begin
            pcnt_nxt  = '0;
            state_nxt = after_on;
          end else begin
            pcnt_nxt  = pcnt_inc;
          end
        end
`ifdef STIM_RAMP_DOWN_EN
        S_RD: begin
          issue     = 1'b1;
          issue_amp = acc_dn[ACC_W-1:4];
          acc_nxt   = acc_dn;
          if (pcnt_inc == PCNT_W'(ramp_q)) begin
            pcnt_nxt  = '0;
            state_nxt = S_OFF;
          end else begin
            pcnt_nxt  = pcnt_inc;
          end
        end
`endif
        S_OFF: begin
          if (pcnt_inc >= off_q) begin
            latch_cfg = 1'b1;
            pcnt_nxt  = '0;
            acc_nxt   = '0;
            state_nxt = start_state;
          end else begin
            pcnt_nxt  = pcnt_inc;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end

    // A tick that finds a request still outstanding is dropped and flagged
    if (issue) begin
      if (pending) begin
        ovr_nxt = 1'b1;
      end else begin
        req_nxt = 1'b1;
        dac_nxt = issue_amp;
      end
    end

    active_nxt = (state_nxt == S_RAMP) || (state_nxt == S_ON) || (state_nxt == S_RD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pcnt        <= '0;
      acc         <= '0;
      pulse_req   <= 1'b0;
      dac_amp     <= '0;
      overrun     <= 1'b0;
      stim_active <= 1'b0;
      freq_q      <= '0;
      amp_q       <= '0;
      ramp_q      <= '0;
      rf_q        <= '0;
      on_q        <= '0;
      off_q       <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pcnt        <= pcnt_nxt;
      acc         <= acc_nxt;
      pulse_req   <= req_nxt;
      dac_amp     <= dac_nxt;
      overrun     <= ovr_nxt;
      stim_active <= active_nxt;
      if (latch_cfg) begin
        freq_q <= freq;
        amp_q  <= amplitude;
        ramp_q <= ramp;
        rf_q   <= ramp_factor;
        on_q   <= on_time;
        off_q  <= off_time;
      end
    end
  end

endmodule

// File: tb/tb_stim_sequencer.sv
// Self-checking bench for stim_sequencer: vector table, directed corner cases and
// randomized bursts against a timeline model of pulse issue times and amplitudes.
`timescale 1ns/1ps
module tb_stim_sequencer;

  typedef struct packed { int ack_dly; int amp; int gap; } vec_t;
  typedef struct packed { int cyc; int amp; } rise_t;
  typedef struct packed { int freq; int ramp; int rf; int amp; int on; int off; } cfg_t;

  logic        clk, reset, enable;
  logic [11:0] freq;
  logic [5:0]  amplitude, ramp;
  logic [9:0]  ramp_factor, off_time;
  logic [7:0]  on_time;
  logic        man_ack, resp_ack, pulse_ack;
  logic        pulse_req, stim_active, overrun;
  logic [5:0]  dac_amp;
  logic [2:0]  state;

  assign pulse_ack = man_ack | resp_ack;

  stim_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .freq(freq), .amplitude(amplitude),
    .ramp(ramp), .ramp_factor(ramp_factor), .on_time(on_time), .off_time(off_time),
    .pulse_ack(pulse_ack), .pulse_req(pulse_req), .dac_amp(dac_amp),
    .stim_active(stim_active), .state(state), .overrun(overrun)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cyc = 0;
  rise_t rises[$];
  rise_t exp_q[$];
  int burst_q[$];
  int ack_tab[$];
  int n_acks = 0;
  int max_lat = 0;
  bit auto_ack = 0;
  vec_t tv[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cyc++;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached (checks %0d)", chk_cnt);
    $fatal(1);
  end

  // Record every rising edge of pulse_req with its amplitude
  initial begin
    rise_t r;
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (pulse_req && !prev_req) begin
        r.cyc = cyc;
        r.amp = int'(dac_amp);
        rises.push_back(r);
      end
      prev_req = pulse_req;
    end
  end

  // Automatic pulse generator: acks each request after a table or random latency
  initial begin
    bit waiting, acked;
    int wait_cnt, lat;
    waiting = 0; acked = 0; wait_cnt = 0; lat = 0;
    resp_ack = 1'b0;
    forever begin
      @(negedge clk);
      resp_ack = 1'b0;
      if (!pulse_req || !auto_ack) begin
        waiting = 0;
        acked   = 0;
      end else if (!acked) begin
        if (!waiting) begin
          waiting  = 1;
          wait_cnt = 0;
          lat = (n_acks < ack_tab.size()) ? ack_tab[n_acks] : int'($urandom_range(max_lat, 0));
        end
        if (wait_cnt >= lat) begin
          resp_ack = 1'b1;
          acked    = 1;
          n_acks++;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic set_cfg(input cfg_t c);
    freq        = 12'(c.freq);
    ramp        = 6'(c.ramp);
    ramp_factor = 10'(c.rf);
    amplitude   = 6'(c.amp);
    on_time     = 8'(c.on);
    off_time    = 10'(c.off);
  endtask

  function automatic cfg_t mk_cfg(int f, int r, int rf, int a, int on, int off);
    cfg_t c;
    c.freq = f; c.ramp = r; c.rf = rf; c.amp = a; c.on = on; c.off = off;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    enable   = 1'b0;
    auto_ack = 0;
    man_ack  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rises.delete();
    ack_tab.delete();
    n_acks = 0;
    @(negedge clk);
  endtask

  task automatic wait_rise(input int idx, input int budget, output bit ok);
    int n;
    n = 0;
    while (rises.size() <= idx && n < budget) begin
      @(negedge clk);
      n++;
    end
    ok = (rises.size() > idx);
    if (!ok) check("rise_timeout", rises.size(), idx + 1);
  endtask

  function automatic void add_vec(int d, int a, int g);
    vec_t v;
    v.ack_dly = d; v.amp = a; v.gap = g;
    tv.push_back(v);
  endfunction

  function automatic int per(cfg_t c);
    return (c.freq < 2) ? 2 : c.freq;
  endfunction

  // Amplitudes of one burst, straight from the phase rules
  function automatic void build_burst(cfg_t c);
    int acc, cap;
    burst_q.delete();
    acc = 0;
    cap = c.amp * 16;
    for (int i = 0; i < c.ramp; i++) begin
      acc = (acc + c.rf > cap) ? cap : acc + c.rf;
      burst_q.push_back(acc / 16);
    end
    for (int i = 0; i < c.on; i++) burst_q.push_back(c.amp);
`ifdef STIM_RAMP_DOWN_EN
    for (int i = 0; i < c.ramp; i++) begin
      acc = (acc > c.rf) ? acc - c.rf : 0;
      burst_q.push_back(acc / 16);
    end
`endif
  endfunction

  // Timeline: first burst with c1 from tick t0, later bursts with c2
  function automatic void build_expected(cfg_t c1, cfg_t c2, int t0, int tend);
    cfg_t c;
    int t;
    rise_t r;
    c = c1;
    t = t0;
    exp_q.delete();
    while (t < tend) begin
      build_burst(c);
      foreach (burst_q[i]) begin
        r.cyc = t + 1;
        r.amp = burst_q[i];
        if (r.cyc < tend) exp_q.push_back(r);
        t += per(c);
      end
      t += (((c.off < 1) ? 1 : c.off) - 1) * per(c);
      c = c2;
      t += per(c);
    end
  endfunction

  function automatic cfg_t rand_cfg();
    return mk_cfg(int'($urandom_range(9, 0)), int'($urandom_range(4, 0)),
                  int'($urandom_range(1023, 0)), int'($urandom_range(63, 0)),
                  int'($urandom_range(4, 0)), int'($urandom_range(3, 0)));
  endfunction

  task automatic run_random(input int it);
    cfg_t c1, c2;
    int c0, tend, n, p;
    localparam int H = 160;
    do_reset();
    c1 = rand_cfg();
    c2 = rand_cfg();
    p = (per(c1) < per(c2)) ? per(c1) : per(c2);
    max_lat = p - 2;
    set_cfg(c1);
    auto_ack = 1;
    enable = 1'b1;
    c0 = cyc;
    @(negedge clk);
    set_cfg(c2);
    while (cyc < c0 + H) @(negedge clk);
    tend = c0 + H - 2;
    build_expected(c1, c2, c0 + 1, tend);
    n = 0;
    foreach (rises[i]) if (rises[i].cyc < tend) n++;
    check($sformatf("rand%0d_count", it), n, exp_q.size());
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      check($sformatf("rand%0d_time%0d", it, i), rises[i].cyc - c0, exp_q[i].cyc - c0);
      check($sformatf("rand%0d_amp%0d", it, i), rises[i].amp, exp_q[i].amp);
    end
    check($sformatf("rand%0d_overrun", it), int'(overrun), 0);
  endtask

  initial begin
    bit ok;
    reset = 1'b1; enable = 1'b0; man_ack = 1'b0;
    set_cfg(mk_cfg(4, 2, 400, 50, 3, 2));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_pulse_req", int'(pulse_req), 0);
    check("rst_dac_amp", int'(dac_amp), 0);
    check("rst_state", int'(state), 0);
    check("rst_stim_active", int'(stim_active), 0);
    check("rst_overrun", int'(overrun), 0);

    // Reference burst: {ack latency, expected amplitude, cycles since previous pulse}
    add_vec(0, 25, 0); add_vec(1, 50, 4); add_vec(2, 50, 4);
    add_vec(0, 50, 4); add_vec(1, 50, 4);
`ifdef STIM_RAMP_DOWN_EN
    add_vec(0, 25, 4); add_vec(2, 0, 4);
`endif
    add_vec(1, 25, 12); add_vec(0, 50, 4);

    do_reset();
    set_cfg(mk_cfg(4, 2, 400, 50, 3, 2));
    foreach (tv[i]) ack_tab.push_back(tv[i].ack_dly);
    auto_ack = 1;
    max_lat = 0;
    enable = 1'b1;
    @(negedge clk);
    check("tbl_stim_active", int'(stim_active), 1);
    check("tbl_state_ramp", int'(state), 1);
    for (int i = 0; i < tv.size(); i++) begin
      wait_rise(i, 40, ok);
      if (ok) begin
        check($sformatf("tbl_amp%0d", i), rises[i].amp, tv[i].amp);
        if (i > 0) check($sformatf("tbl_gap%0d", i), rises[i].cyc - rises[i-1].cyc, tv[i].gap);
      end
    end
    check("tbl_overrun", int'(overrun), 0);

    // Ack withheld for many cycles: overrun, single request, phase still advances
    do_reset();
    set_cfg(mk_cfg(4, 0, 0, 20, 3, 2));
    enable = 1'b1;
    repeat (12) @(negedge clk);
    check("ovr_flag", int'(overrun), 1);
    check("ovr_req_held", int'(pulse_req), 1);
    check("ovr_one_req", rises.size(), 1);
    check("ovr_state_off", int'(state), 4);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("ovr_req_released", int'(pulse_req), 0);

    // Ack coincident with tick: old request completes, new one issues, no overrun
    do_reset();
    set_cfg(mk_cfg(4, 2, 400, 50, 3, 2));
    enable = 1'b1;
    repeat (2) @(negedge clk);
    check("coin_first_amp", int'(dac_amp), 25);
    repeat (3) @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("coin_req_high", int'(pulse_req), 1);
    check("coin_new_amp", int'(dac_amp), 50);
    check("coin_overrun", int'(overrun), 0);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("coin_req_done", int'(pulse_req), 0);

    // Enable dropped mid-ON with a request pending
    do_reset();
    set_cfg(mk_cfg(4, 0, 0, 40, 20, 1));
    enable = 1'b1;
    repeat (3) @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    check("dis_state_on", int'(state), 2);
    check("dis_req_pending", int'(pulse_req), 1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    check("dis_req_done", int'(pulse_req), 0);
    check("dis_state_idle", int'(state), 0);
    check("dis_inactive", int'(stim_active), 0);

    // Reset mid-handshake: immediate clear, late ack ignored
    do_reset();
    set_cfg(mk_cfg(4, 0, 0, 40, 20, 1));
    enable = 1'b1;
    repeat (7) @(negedge clk);
    check("ar_pre_overrun", int'(overrun), 1);
    reset = 1'b1;
    #1;
    check("ar_pulse_req", int'(pulse_req), 0);
    check("ar_dac_amp", int'(dac_amp), 0);
    check("ar_state", int'(state), 0);
    check("ar_stim_active", int'(stim_active), 0);
    check("ar_overrun", int'(overrun), 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("ar_late_ack_req", int'(pulse_req), 0);
    check("ar_late_ack_state", int'(state), 0);

    // Everything zero, freq=1: no pulses, no overrun, no hang
    do_reset();
    set_cfg(mk_cfg(1, 0, 0, 30, 0, 0));
    enable = 1'b1;
    repeat (20) @(negedge clk);
    check("zero_no_pulses", rises.size(), 0);
    check("zero_overrun", int'(overrun), 0);
    check("zero_state_off", int'(state), 4);
    check("zero_inactive", int'(stim_active), 0);

    // freq=1 behaves as a 2-cycle period
    do_reset();
    set_cfg(mk_cfg(1, 0, 0, 17, 1, 0));
    auto_ack = 1;
    max_lat = 0;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_rise(i, 20, ok);
      if (ok) begin
        check($sformatf("f1_amp%0d", i), rises[i].amp, 17);
        if (i > 0) check($sformatf("f1_gap%0d", i), rises[i].cyc - rises[i-1].cyc, 4);
      end
    end
    check("f1_overrun", int'(overrun), 0);

    for (int it = 0; it < 12; it++) run_random(it);

    do_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  stimulator main clock (20 kHz); all logic on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have port: enable  input  1  stimulation enable (conf1[20]).
REQ-004 SHALL have port: freq  input  12  pulse period in clk cycles (400 = 50 Hz).
REQ-005 SHALL have port: amplitude  input  6  target amplitude, mA.
REQ-006 SHALL have port: ramp  input  6  ramp-up length, pulses.
REQ-007 SHALL have port: ramp_factor  input  10  amplitude increment per ramp pulse, 1/16 mA units.
REQ-008 SHALL have port: on_time  input  8  full-amplitude pulses per burst.
REQ-009 SHALL have port: off_time  input  10  silent pulse periods between bursts.
REQ-010 SHALL have port: pulse_ack  input  1  one-cycle pulse-generator completion strobe.
REQ-011 SHALL have port: pulse_req  output  1  pulse request to pulse generator.
REQ-012 SHALL have port: dac_amp  output  6  amplitude for the requested pulse.
REQ-013 SHALL have port: stim_active  output  1  high in RAMP/ON/RAMP_DOWN.
REQ-014 SHALL have port: state  output  3  FSM state code.
REQ-015 SHALL have port: overrun  output  1  sticky; period tick occurred while pulse_req was pending.

Function
REQ-016 FSM states SHALL be IDLE=0, RAMP=1, ON=2, RAMP_DOWN=3, OFF=4.
REQ-017 Period counter SHALL count 0..P-1 and wrap, P = max(freq,2); count==0 is the tick; it is held at 0 while in IDLE.
REQ-018 IDLE->RAMP on enable=1; config inputs SHALL be latched on every entry to RAMP and held constant for the burst.
REQ-019 On each tick in RAMP/ON/RAMP_DOWN, pulse_req SHALL rise on the following cycle with dac_amp valid, and stay high until the cycle after pulse_ack.
REQ-020 Accumulator acc (10 bits, 1/16 mA) SHALL be 0 on RAMP entry; each RAMP pulse sets acc = min(acc+ramp_factor, amplitude*16) before issue; dac_amp = acc[9:4].
REQ-021 RAMP->ON after `ramp` pulses issued; ramp=0 SHALL skip RAMP (dac_amp = amplitude).
REQ-022 ON pulses SHALL use dac_amp = amplitude; ON->RAMP_DOWN (macro on) or OFF (macro off) after on_time pulses; on_time=0 skips ON.
REQ-023 OFF SHALL issue no pulses, count off_time ticks, then go to RAMP (latching config); off_time=0 goes to RAMP at the next tick.
REQ-024 Tick while pulse_req is high SHALL not issue a new pulse, SHALL set overrun, and SHALL still count toward the phase length.
REQ-025 enable=0 in any state SHALL complete any pending handshake, then go to IDLE with acc=0; ack without pending req SHALL be ignored.
REQ-026 pulse_ack coincident with a tick SHALL complete the old request and issue the new one, with no overrun.

Reset
REQ-027 reset=1 SHALL asynchronously force state=IDLE, pulse_req=0, dac_amp=0, stim_active=0, overrun=0, and all counters and acc to 0.
REQ-028 Reset mid-handshake SHALL drop pulse_req immediately; the next ack SHALL be ignored.

Configuration
REQ-029 Macro STIM_RAMP_DOWN_EN defined: RAMP_DOWN issues `ramp` pulses, acc = max(acc-ramp_factor, 0) before each, then goes to OFF; ramp=0 skips it.
REQ-030 Macro undefined: RAMP_DOWN SHALL be unreachable and ON goes directly to OFF.

Verification
REQ-031 freq=4, ramp=2, ramp_factor=400, amplitude=50, on_time=3, off_time=2, macro off -> dac_amp sequence 25,50,50,50,50; no pulses for 2 periods; repeats; pulses 4 cycles apart.
REQ-032 Same, macro on -> sequence 25,50,50,50,50,25,0; then OFF for 2 periods.
REQ-033 Hold pulse_ack low for 10 cycles with freq=4 -> overrun=1; only one request outstanding; phase counts still advance.
REQ-034 Drop enable mid-ON with a request pending -> request completes on ack, then state=IDLE, stim_active=0.
REQ-035 Assert reset with pulse_req high -> all outputs 0 the same cycle; late ack ignored.
REQ-036 ramp=0, on_time=0, off_time=0, freq=1 -> no pulses issued; period is 2 cycles; no hang or overrun.
